// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - execute-stage multiply/divide unit with private HI/LO registers
// Define MDU_DIV_EN to build div/divu; without it ops 3/4 behave as none.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDU_op,
  output logic        start,
  output logic        busy,
  output logic [31:0] MDU_out
);
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  logic [31:0]   hi, lo, res_hi, res_lo;
  logic [CW-1:0] cnt;
  logic          is_long;
  logic [31:0]   nxt_hi, nxt_lo;
  logic [CW-1:0] nxt_cnt;
  logic [63:0]   prod_s, prod_u;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

`ifdef MDU_DIV_EN
  logic [31:0] abs_a, abs_b, dvd, dvs, uq, ur, sq, sr;

  // One unsigned divider serves both ops; signed div works on magnitudes.
  assign abs_a = A[31] ? -A : A;
  assign abs_b = B[31] ? -B : B;
  assign dvd   = (MDU_op == OP_DIV) ? abs_a : A;
  assign dvs   = (MDU_op == OP_DIV) ? abs_b : B;
  assign uq    = dvd / ((dvs == 32'd0) ? 32'd1 : dvs);
  assign ur    = dvd % ((dvs == 32'd0) ? 32'd1 : dvs);
  assign sq    = (A[31] ^ B[31]) ? -uq : uq;
  assign sr    = A[31] ? -ur : ur;
`endif

  always_comb begin
    is_long = 1'b0;
    nxt_hi  = prod_s[63:32];
    nxt_lo  = prod_s[31:0];
    nxt_cnt = CW'(MULT_CYCLES);
    case (MDU_op)
      OP_MULT: is_long = 1'b1;
      OP_MULTU: begin
        is_long = 1'b1;
        nxt_hi  = prod_u[63:32];
        nxt_lo  = prod_u[31:0];
      end
`ifdef MDU_DIV_EN
      OP_DIV, OP_DIVU: begin
        is_long = 1'b1;
        nxt_cnt = CW'(DIV_CYCLES);
        // Divide by zero latches the current HI/LO, so the writeback is a no-op.
        if (B == 32'd0) begin
          nxt_hi = hi;
          nxt_lo = lo;
        end else if (MDU_op == OP_DIV) begin
          nxt_hi = sr;
          nxt_lo = sq;
        end else begin
          nxt_hi = ur;
          nxt_lo = uq;
        end
      end
`endif
      default: ;
    endcase
  end

  assign start = is_long & ~busy;

  always_comb begin
    MDU_out = 32'd0;
    if (MDU_op == OP_MFHI) MDU_out = hi;
    else if (MDU_op == OP_MFLO) MDU_out = lo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi     <= 32'd0;
      lo     <= 32'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        hi   <= res_hi;
        lo   <= res_lo;
        busy <= 1'b0;
      end
    end else if (is_long) begin
      res_hi <= nxt_hi;
      res_lo <= nxt_lo;
      cnt    <= nxt_cnt;
      busy   <= 1'b1;
    end else if (MDU_op == OP_MTHI) begin
      hi <= A;
    end else if (MDU_op == OP_MTLO) begin
      lo <= A;
    end
  end
endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - directed and random checks of e_mdu against a cycle-count model
// Div expectations follow MDU_DIV_EN, matching the build of the design.
module tb_e_mdu;
  localparam int NM = 5;
  localparam int ND = 10;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  MDU_op;
  logic        start, busy;
  logic [31:0] MDU_out;

  always #5 clk = ~clk;

  e_mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDU_op(MDU_op),
    .start(start), .busy(busy), .MDU_out(MDU_out)
  );

  int errors = 0;
  int checks = 0;
  int edges = 0;
  int done_at = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit launches(input logic [3:0] op);
    return (op == 4'd1) || (op == 4'd2) || (DIV_EN && (op == 4'd3 || op == 4'd4));
  endfunction

  // Architectural result of a long op, plus its latency.
  task automatic model_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] rh, output logic [31:0] rl, output int n);
    int ia, ib;
    longint sp, sq, sr;
    longint unsigned ua, ub, up;
    ia = a; ib = b; ua = a; ub = b;
    rh = m_hi; rl = m_lo; n = NM;
    case (op)
      4'd1: begin sp = longint'(ia) * longint'(ib); rh = sp[63:32]; rl = sp[31:0]; end
      4'd2: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
      4'd3: begin
        n = ND;
        if (b != 0) begin
          sq = longint'(ia) / longint'(ib);
          sr = longint'(ia) % longint'(ib);
          rh = sr[31:0]; rl = sq[31:0];
        end
      end
      4'd4: begin
        n = ND;
        if (b != 0) begin rh = a % b; rl = a / b; end
      end
      default: ;
    endcase
  endtask

  // One clock cycle: drive at negedge, check combinational and busy, model the edge.
  task automatic step(input logic rst, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit mb, ms;
    logic [31:0] mo;
    int n;
    reset = rst; MDU_op = op; A = a; B = b;
    #1;
    mb = edges < done_at;
    ms = launches(op) && !mb;
    mo = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
    chk("busy", {31'd0, busy}, {31'd0, mb});
    chk("start", {31'd0, start}, {31'd0, ms});
    chk("mdu_out", MDU_out, mo);
    n = NM;
    if (ms && !rst) model_result(op, a, b, p_hi, p_lo, n);
    @(posedge clk);
    edges++;
    if (rst) begin
      m_hi = 32'd0; m_lo = 32'd0; done_at = edges;
    end else if (mb) begin
      if (edges == done_at) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (ms) begin
      done_at = edges + n;
    end else if (op == 4'd5) begin
      m_hi = a;
    end else if (op == 4'd6) begin
      m_lo = a;
    end
    @(negedge clk);
  endtask

  // Read HI/LO without clocking and compare against a literal.
  task automatic peek(input string tag, input logic [3:0] op, input logic [31:0] exp);
    reset = 1'b0; MDU_op = op; A = 32'd0; B = 32'd0;
    #1;
    chk(tag, MDU_out, exp);
  endtask

  initial begin
    reset = 1'b1; MDU_op = 4'd0; A = 32'd0; B = 32'd0;
    @(negedge clk);
    step(1'b1, 4'd0, 32'd0, 32'd0);
    peek("reset_hi", 4'd7, 32'd0);
    peek("reset_lo", 4'd8, 32'd0);

    // mult -2 * 3
    step(1'b0, 4'd1, 32'hFFFFFFFE, 32'd3);
    repeat (NM) step(1'b0, 4'd0, 32'd0, 32'd0);
    peek("mult_hi", 4'd7, 32'hFFFFFFFF);
    peek("mult_lo", 4'd8, 32'hFFFFFFFA);

    // multu with mfhi during busy
    step(1'b0, 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step(1'b0, 4'd7, 32'd0, 32'd0);
    repeat (NM - 1) step(1'b0, 4'd8, 32'd0, 32'd0);
    peek("multu_hi", 4'd7, 32'hFFFFFFFE);
    peek("multu_lo", 4'd8, 32'h00000001);

    // div, divide overflow, and back-to-back issue
    step(1'b0, 4'd3, 32'hFFFFFFF9, 32'd2);
    repeat (ND) step(1'b0, 4'd0, 32'd0, 32'd0);
    if (DIV_EN) begin
      peek("div_hi", 4'd7, 32'hFFFFFFFF);
      peek("div_lo", 4'd8, 32'hFFFFFFFD);
    end else begin
      peek("nodiv_hi", 4'd7, 32'hFFFFFFFE);
      peek("nodiv_lo", 4'd8, 32'h00000001);
    end
    step(1'b0, 4'd3, 32'h80000000, 32'hFFFFFFFF);
    repeat (ND) step(1'b0, 4'd0, 32'd0, 32'd0);
    step(1'b0, 4'd3, 32'd10, 32'd3);
    repeat (ND) step(1'b0, 4'd0, 32'd0, 32'd0);

    // mthi/mtlo then divide by zero
    step(1'b0, 4'd5, 32'h12345678, 32'd0);
    step(1'b0, 4'd6, 32'h9ABCDEF0, 32'd0);
    step(1'b0, 4'd4, 32'd55, 32'd0);
    repeat (ND) step(1'b0, 4'd0, 32'd0, 32'd0);
    peek("divz_hi", 4'd7, 32'h12345678);
    peek("divz_lo", 4'd8, 32'h9ABCDEF0);

    // reset on busy cycle 3, after an ignored mthi
    step(1'b0, 4'd1, 32'd7, 32'd9);
    step(1'b0, 4'd0, 32'd0, 32'd0);
    step(1'b0, 4'd5, 32'hAAAA5555, 32'd0);
    step(1'b1, 4'd0, 32'd0, 32'd0);
    step(1'b0, 4'd0, 32'd0, 32'd0);
    peek("rst_hi", 4'd7, 32'd0);
    peek("rst_lo", 4'd8, 32'd0);

    // random traffic, including ops while busy and occasional resets
    for (int i = 0; i < 120; i++) begin
      logic [3:0]  op;
      logic [31:0] ra, rb;
      op = 4'($urandom_range(0, 11));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000000F;
      step(($urandom_range(0, 59) == 0), op, ra, rb);
    end
    repeat (ND + 1) step(1'b0, 4'd0, 32'd0, 32'd0);
    step(1'b0, 4'd7, 32'd0, 32'd0);
    step(1'b0, 4'd8, 32'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit of the five-stage pipelined MIPS core. Sits beside the ALU in E and takes the same forwarded rs/rt operands. Runs mult/multu/div/divu as multi-cycle operations into private HI/LO registers, executes mthi/mtlo, and returns HI or LO for mfhi/mflo. Drives `busy`/`start` to the hazard unit, which stalls D while an MDU instruction waits behind an active operation.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (≥1).
- `clk` in 1: clock; the only clock; all state on rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `A` in 32: forwarded rs value.
- `B` in 32: forwarded rt value.
- `MDU_op` in 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9–15 treated as none. Encodings are `MDU_*` macros in const.v.
- `start` out 1: combinational; 1 when `MDU_op` is 1–4 and `busy`=0.
- `busy` out 1: registered; 1 while an operation is in flight.
- `MDU_out` out 32: combinational; HI for mfhi, LO for mflo, else 0.

## Operation
- State: `HI`, `LO`, `busy`, down-counter `cnt`, and latched result `res_hi`/`res_lo`.
- Idle (`busy`=0), on a clock edge:
  - op 1–4: compute result from A/B, latch into `res_hi`/`res_lo`, load `cnt` with MULT_CYCLES or DIV_CYCLES, set `busy`=1.
  - mthi: HI←A. mtlo: LO←A.
  - All other ops: no state change.
- Busy: decrement `cnt` each edge. On the edge where `cnt`=1, write HI←`res_hi`, LO←`res_lo` and clear `busy`.
- Any `MDU_op` arriving while busy is ignored: no start, no mt write. The hazard unit prevents this. mfhi/mflo while busy return the old HI/LO.
- Arithmetic:
  - mult: signed 32×32→64, HI=prod[63:32], LO=prod[31:0]. multu: unsigned.
  - div: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend (A).
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - B=0 for div/divu: the operation still runs for its full busy time, but HI/LO are left unchanged.
- The result is computed combinationally at start and held. The counter only models latency; an iterative datapath is permitted if it gives bit-identical results and identical cycle timing.

## Timing
- Reset (sync): HI=0, LO=0, `busy`=0, `cnt`=0, `res_*`=0. Reset mid-operation aborts it; HI/LO read 0 the next cycle.
- Start sampled at edge E0. `busy`=1 for exactly N cycles (edges E0..E0+N). HI/LO are updated at edge E0+N and visible to mfhi/mflo in the cycle after E0+N, the same cycle `busy` reads 0.
- Back-to-back: a new mult/div is accepted in the first cycle `busy`=0. Minimum issue spacing is N+1 cycles.
- `start` and `busy` are never 1 in the same cycle. The hazard unit stalls on (`start` | `busy`) when D holds an MDU op.
- mthi/mtlo write at the sampling edge; mfhi in the next cycle sees the new value. `MDU_out` has zero latency from `MDU_op`.
- When `busy`=0 and `cnt`=0, counter wrap is impossible; implementations must not decrement `cnt` below 0.

## Configuration
- `MDU_DIV_EN` defined: div/divu supported as above.
- `MDU_DIV_EN` undefined:
  - No divider logic.
  - ops 3/4 behave as none: `start`=0, no busy, HI/LO unchanged.
  - DIV_CYCLES is ignored.

## Test plan
- Reset then mult A=0xFFFFFFFE(-2), B=3 → `busy`=1 for 5 cycles; next cycle mfhi=0xFFFFFFFF, mflo=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001. mfhi issued during busy returns the prior HI.
- div A=-7(0xFFFFFFF9), B=2 → 10 busy cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi A=0x12345678, mtlo A=0x9ABCDEF0, then divu B=0 → 10 busy cycles; HI/LO keep 0x12345678/0x9ABCDEF0.
- Start mult, assert `reset` on busy cycle 3 → next cycle `busy`=0, HI=LO=0; a mthi issued while busy (before the reset) has no effect.
- Build without `MDU_DIV_EN`: div A=10, B=3 → `start`=0, `busy` stays 0, HI/LO unchanged; mult still takes 5 cycles.
